// File: rtl/kmac_encode_string_stream.sv
// kmac_encode_string_stream
// Streams encode_string(S), or bytepad(encode_string(S), PAD_W), one byte per
// accepted handshake. Layout: optional left_encode(PAD_W) header,
// left_encode(8*L), the L string bytes, then optional zero padding up to a
// multiple of PAD_W. The output byte/valid/last are registered and change
// only on capture, on an accepted byte, or when the stream finishes.
module kmac_encode_string_stream #(
    parameter int MAX_LEN = 32,
    parameter int PAD_W   = 168
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           mode,
    input  logic [MAX_LEN*8-1:0]           str_bytes,
    input  logic [$clog2(MAX_LEN+1)-1:0]   str_len,
    output logic [7:0]                     out_byte,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic                           busy,
    output logic                           enc_done
);

    localparam int LEN_W      = $clog2(MAX_LEN + 1);
    localparam int IDX_W      = LEN_W + 1;
    localparam int BL_W       = LEN_W + 3;               // width of 8*L
    localparam int LENB       = (BL_W + 7) / 8;          // max bytes of 8*L
    localparam int BB_W       = LENB * 8;
    localparam int SEL_W      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int KB_W       = (LENB > 1) ? $clog2(LENB) : 1;
    // Longest stream: pad header, length prefix, length bytes, string, padding.
    localparam int MAX_STREAM = 2 + 1 + LENB + MAX_LEN + PAD_W;
    localparam int CNT_W      = $clog2(MAX_STREAM + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PAD_HDR = 3'd1,
        LEN_N   = 3'd2,
        LEN_X   = 3'd3,
        STR     = 3'd4,
        ZPAD    = 3'd5,
        DONE    = 3'd6
    } state_t;

    typedef struct packed {
        state_t             st;
        logic [IDX_W-1:0]   idx;
    } pos_t;

    typedef logic [MAX_LEN-1:0][7:0] str_t;

    // Byte count modulo PAD_W after one more accepted byte.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        if (c >= CNT_W'(PAD_W - 1)) begin
            cnt_inc = '0;
        end else begin
            cnt_inc = c + CNT_W'(1);
        end
    endfunction

    // Big-endian bytes of 8*L, least significant byte at index 0.
    function automatic logic [LENB-1:0][7:0] bitlen_bytes(input logic [LEN_W-1:0] len);
        logic [BB_W-1:0] bl;
        bl = BB_W'({len, 3'b000});
        bitlen_bytes = bl;
    endfunction

    // Minimum byte count (at least one) needed to hold 8*L.
    function automatic logic [IDX_W-1:0] calc_n(input logic [LEN_W-1:0] len);
        logic [LENB-1:0][7:0] bb;
        bb = bitlen_bytes(len);
        calc_n = IDX_W'(1);
        for (int b = 1; b < LENB; b++) begin
            if (bb[b] != 8'h00) begin
                calc_n = IDX_W'(b + 1);
            end
        end
    endfunction

    function automatic logic emitting(input state_t s);
        emitting = (s == PAD_HDR) || (s == LEN_N) || (s == LEN_X) ||
                   (s == STR) || (s == ZPAD);
    endfunction

    // Stream position following p, given the byte count after p is accepted.
    // Empty sections (no string bytes, no padding needed) are skipped.
    function automatic pos_t advance(input pos_t p, input logic [CNT_W-1:0] c_after,
                                     input logic m, input logic [LEN_W-1:0] len,
                                     input logic [IDX_W-1:0] n);
        pos_t   r;
        state_t tail;
        tail  = (m && (c_after != '0)) ? ZPAD : DONE;
        r.st  = IDLE;
        r.idx = '0;
        case (p.st)
            PAD_HDR: begin
                if (p.idx == '0) begin
                    r.st  = PAD_HDR;
                    r.idx = IDX_W'(1);
                end else begin
                    r.st  = LEN_N;
                end
            end
            LEN_N: r.st = LEN_X;
            LEN_X: begin
                if (p.idx != (n - IDX_W'(1))) begin
                    r.st  = LEN_X;
                    r.idx = p.idx + IDX_W'(1);
                end else if (len != '0) begin
                    r.st  = STR;
                end else begin
                    r.st  = tail;
                end
            end
            STR: begin
                if (p.idx != (IDX_W'(len) - IDX_W'(1))) begin
                    r.st  = STR;
                    r.idx = p.idx + IDX_W'(1);
                end else begin
                    r.st  = tail;
                end
            end
            ZPAD:    r.st = (c_after != '0) ? ZPAD : DONE;
            default: r.st = IDLE;
        endcase
        advance = r;
    endfunction

    // Byte value at stream position p.
    function automatic logic [7:0] byte_at(input pos_t p, input logic [LEN_W-1:0] len,
                                           input logic [IDX_W-1:0] n, input str_t s);
        logic [LENB-1:0][7:0] bb;
        logic [IDX_W-1:0]     k;
        bb = bitlen_bytes(len);
        k  = n - IDX_W'(1) - p.idx;
        case (p.st)
            PAD_HDR: byte_at = (p.idx == '0) ? 8'h01 : 8'(PAD_W);
            LEN_N:   byte_at = 8'(n);
            LEN_X:   byte_at = bb[k[KB_W-1:0]];
            STR:     byte_at = s[p.idx[SEL_W-1:0]];
            ZPAD:    byte_at = 8'h00;
            default: byte_at = 8'h00;
        endcase
    endfunction

    state_t             state_r;
    logic [IDX_W-1:0]   idx_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               mode_r;
    logic [LEN_W-1:0]   len_r;
    logic [IDX_W-1:0]   n_r;
    str_t               str_r;
    logic [7:0]         out_byte_r;
    logic               out_valid_r;
    logic               out_last_r;
    logic               busy_r;
    logic               enc_done_r;

    logic [LEN_W-1:0]   sat_len_s;
    logic               capture_s;
    logic               accept_s;
    logic               ctx_mode_s;
    logic [LEN_W-1:0]   ctx_len_s;
    logic [IDX_W-1:0]   ctx_n_s;
    str_t               ctx_str_s;
    pos_t               cur_pos_s;
    pos_t               nxt_pos_s;
    pos_t               look_s;
    logic [CNT_W-1:0]   nxt_cnt_s;
    logic [7:0]         nxt_byte_s;
    logic               nxt_valid_s;
    logic               nxt_last_s;

    // Capture qualification: start is taken only when idle (or finishing) and out of reset.
    always_comb begin
        if (str_len > LEN_W'(MAX_LEN)) begin
            sat_len_s = LEN_W'(MAX_LEN);
        end else begin
            sat_len_s = str_len;
        end
        capture_s = ~rst & start & ((state_r == IDLE) | (state_r == DONE));
        accept_s  = out_valid_r & out_ready;
    end

    // Stream context: live inputs in the capture cycle, captured copy afterwards.
    always_comb begin
        ctx_mode_s = mode_r;
        ctx_len_s  = len_r;
        ctx_n_s    = n_r;
        ctx_str_s  = str_r;
        if (capture_s) begin
            ctx_mode_s = mode;
            ctx_len_s  = sat_len_s;
            ctx_n_s    = calc_n(sat_len_s);
            ctx_str_s  = str_bytes;
        end else begin
            ctx_mode_s = mode_r;
        end
    end

    // Next stream position and the registered output values for that position.
    always_comb begin
        cur_pos_s.st  = state_r;
        cur_pos_s.idx = idx_r;
        nxt_pos_s     = cur_pos_s;
        nxt_cnt_s     = cnt_r;
        look_s        = cur_pos_s;
        nxt_byte_s    = 8'h00;
        nxt_valid_s   = 1'b0;
        nxt_last_s    = 1'b0;
        if (capture_s) begin
            nxt_pos_s.st  = mode ? PAD_HDR : LEN_N;
            nxt_pos_s.idx = '0;
            nxt_cnt_s     = '0;
        end else if (accept_s) begin
            nxt_cnt_s = cnt_inc(cnt_r);
            nxt_pos_s = advance(cur_pos_s, nxt_cnt_s, ctx_mode_s, ctx_len_s, ctx_n_s);
        end else if (state_r == DONE) begin
            nxt_pos_s.st  = IDLE;
            nxt_pos_s.idx = '0;
        end else begin
            nxt_pos_s = cur_pos_s;
        end
        if (emitting(nxt_pos_s.st)) begin
            look_s      = advance(nxt_pos_s, cnt_inc(nxt_cnt_s), ctx_mode_s, ctx_len_s, ctx_n_s);
            nxt_valid_s = 1'b1;
            nxt_byte_s  = byte_at(nxt_pos_s, ctx_len_s, ctx_n_s, ctx_str_s);
            nxt_last_s  = (look_s.st == DONE);
        end else begin
            nxt_valid_s = 1'b0;
            nxt_byte_s  = 8'h00;
            nxt_last_s  = 1'b0;
        end
    end

    // State, counters, captured data and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            idx_r       <= '0;
            cnt_r       <= '0;
            mode_r      <= 1'b0;
            len_r       <= '0;
            n_r         <= '0;
            str_r       <= '0;
            out_byte_r  <= 8'h00;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            enc_done_r  <= 1'b0;
        end else begin
            state_r     <= nxt_pos_s.st;
            idx_r       <= nxt_pos_s.idx;
            cnt_r       <= nxt_cnt_s;
            out_byte_r  <= nxt_byte_s;
            out_valid_r <= nxt_valid_s;
            out_last_r  <= nxt_last_s;
            busy_r      <= emitting(nxt_pos_s.st);
            enc_done_r  <= (nxt_pos_s.st == DONE);
            if (capture_s) begin
                mode_r <= ctx_mode_s;
                len_r  <= ctx_len_s;
                n_r    <= ctx_n_s;
                str_r  <= ctx_str_s;
            end
        end
    end

    // busy also covers the capture cycle itself, so start is refused from then on.
    assign busy      = busy_r | capture_s;
    assign out_byte  = out_byte_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign enc_done  = enc_done_r;

endmodule

// File: tb/tb_kmac_encode_string_stream.sv
// Directed bench for kmac_encode_string_stream: table of streams with
// hand-computed headers/lengths, plus reset-abort and back-to-back start sequences.
module tb_kmac_encode_string_stream;

    localparam int MAX_LEN = 32;
    localparam int PAD_W   = 168;
    localparam int LEN_W   = 6;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 mode;
    logic [MAX_LEN*8-1:0] str_bytes;
    logic [LEN_W-1:0]     str_len;
    logic [7:0]           out_byte;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic                 busy;
    logic                 enc_done;

    always #5 clk = ~clk;

    kmac_encode_string_stream #(.MAX_LEN(MAX_LEN), .PAD_W(PAD_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .str_bytes (str_bytes),
        .str_len   (str_len),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .enc_done  (enc_done)
    );

    typedef struct {
        logic             m;
        logic [LEN_W-1:0] len_in;
        logic [7:0]       base;
        logic [39:0]      hdr;      // header bytes, first byte in bits 39:32
        int               hdr_n;
        int               eff;      // effective string length after saturation
        int               total;
        bit               rnd;      // pseudo-random out_ready
        bit               restart;  // extra start pulse mid-stream
    } vec_t;

    vec_t       vecs [10];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] got_q [$];
    logic       last_q [$];
    int         busy_cnt;
    int         done_cnt;
    int         done_cyc;
    int         last_acc_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input vec_t v, input int i);
        logic [39:0] h;
        h = v.hdr;
        if (i < v.hdr_n) begin
            exp_byte = h[39-8*i -: 8];
        end else if (i < v.hdr_n + v.eff) begin
            exp_byte = v.base + 8'(i - v.hdr_n);
        end else begin
            exp_byte = 8'h00;
        end
    endfunction

    task automatic run_stream(input vec_t v);
        bit         stalled;
        logic [7:0] hb;
        logic       hl;
        int         cyc;
        got_q.delete();
        last_q.delete();
        busy_cnt     = 0;
        done_cnt     = 0;
        done_cyc     = -1;
        last_acc_cyc = -1;
        stalled      = 1'b0;
        hb           = 8'h00;
        hl           = 1'b0;
        @(negedge clk);
        for (int i = 0; i < MAX_LEN; i++) str_bytes[i*8 +: 8] = v.base + 8'(i);
        mode    = v.m;
        str_len = v.len_in;
        start   = 1'b1;
        cyc     = 0;
        while (cyc < 2000 && !(done_cyc >= 0 && cyc > done_cyc + 2)) begin
            if (cyc > 0) begin
                @(negedge clk);
                start = 1'b0;
                if (v.restart && cyc == 3) begin
                    start     = 1'b1;
                    mode      = ~v.m;
                    str_len   = 6'd7;
                    str_bytes = {MAX_LEN{8'hEE}};
                end
            end
            out_ready = v.rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            if (busy) busy_cnt++;
            if (enc_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (stalled) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_byte", 32'(out_byte), 32'(hb));
                chk("stall_last", 32'(out_last), 32'(hl));
            end
            if (!out_valid) begin
                chk("idle_byte", 32'(out_byte), 32'd0);
                chk("idle_last", 32'(out_last), 32'd0);
            end
            if (out_valid && out_ready) begin
                got_q.push_back(out_byte);
                last_q.push_back(out_last);
                last_acc_cyc = cyc;
            end
            stalled = out_valid && !out_ready;
            hb      = out_byte;
            hl      = out_last;
            cyc++;
        end
        start = 1'b0;
        chk("timeout", 32'(done_cyc >= 0), 32'd1);
    endtask

    task automatic check_vec(input int k, input vec_t v);
        chk($sformatf("v%0d_count", k), 32'(got_q.size()), 32'(v.total));
        for (int i = 0; i < v.total && i < got_q.size(); i++) begin
            chk($sformatf("v%0d_byte%0d", k, i), 32'(got_q[i]), 32'(exp_byte(v, i)));
            chk($sformatf("v%0d_last%0d", k, i), 32'(last_q[i]), 32'(i == v.total - 1));
        end
        chk($sformatf("v%0d_done_pulses", k), 32'(done_cnt), 32'd1);
        chk($sformatf("v%0d_done_gap", k), 32'(done_cyc - last_acc_cyc), 32'd1);
        if (!v.rnd) begin
            chk($sformatf("v%0d_busy_cycles", k), 32'(busy_cnt), 32'(v.total + 1));
            chk($sformatf("v%0d_stream_cycles", k), 32'(last_acc_cyc), 32'(v.total));
        end
    endtask

    task automatic sample_outs(input string name, input logic v, input logic [7:0] b,
                               input logic l, input logic bz, input logic d);
        chk({name, "_valid"}, 32'(out_valid), 32'(v));
        chk({name, "_byte"}, 32'(out_byte), 32'(b));
        chk({name, "_last"}, 32'(out_last), 32'(l));
        chk({name, "_busy"}, 32'(busy), 32'(bz));
        chk({name, "_done"}, 32'(enc_done), 32'(d));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 6'd0,  8'h00, 40'h0100000000, 2, 0,  2,   1'b0, 1'b0};
        vecs[1] = '{1'b0, 6'd3,  8'h61, 40'h0118000000, 2, 3,  5,   1'b0, 1'b0};
        vecs[2] = '{1'b0, 6'd32, 8'h80, 40'h0201000000, 3, 32, 35,  1'b0, 1'b0};
        vecs[3] = '{1'b1, 6'd0,  8'h00, 40'h01A8010000, 4, 0,  168, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 6'd31, 8'h10, 40'h01F8000000, 2, 31, 33,  1'b0, 1'b0};
        vecs[5] = '{1'b0, 6'd50, 8'h20, 40'h0201000000, 3, 32, 35,  1'b0, 1'b0};
        vecs[6] = '{1'b1, 6'd5,  8'h41, 40'h01A8012800, 4, 5,  168, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 6'd32, 8'hC0, 40'h01A8020100, 5, 32, 168, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 6'd3,  8'h61, 40'h0118000000, 2, 3,  5,   1'b1, 1'b1};
        vecs[9] = '{1'b1, 6'd5,  8'h41, 40'h01A8012800, 4, 5,  168, 1'b1, 1'b1};

        rst       = 1'b1;
        start     = 1'b0;
        mode      = 1'b0;
        str_len   = '0;
        str_bytes = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        sample_outs("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        for (int k = 0; k < 10; k++) begin
            run_stream(vecs[k]);
            check_vec(k, vecs[k]);
        end

        // Reset after the second accepted byte aborts the stream.
        @(negedge clk);
        for (int i = 0; i < MAX_LEN; i++) str_bytes[i*8 +: 8] = 8'h61 + 8'(i);
        mode = 1'b0; str_len = 6'd3; start = 1'b1; out_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1; start = 1'b1;
        @(negedge clk); #1;
        sample_outs("abort", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0; start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            sample_outs($sformatf("abort_quiet%0d", c), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        end
        run_stream(vecs[1]);
        check_vec(10, vecs[1]);

        // A start arriving in the enc_done cycle is accepted.
        @(negedge clk);
        mode = 1'b0; str_len = 6'd0; start = 1'b1; out_ready = 1'b1;
        @(negedge clk); start = 1'b0; #1;
        sample_outs("b2b_a0", 1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
        @(negedge clk); #1;
        sample_outs("b2b_a1", 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        str_bytes = '0; str_bytes[7:0] = 8'h5A; str_len = 6'd1; start = 1'b1; #1;
        sample_outs("b2b_done", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        @(negedge clk); start = 1'b0; #1;
        sample_outs("b2b_b0", 1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
        @(negedge clk); #1;
        sample_outs("b2b_b1", 1'b1, 8'h08, 1'b0, 1'b1, 1'b0);
        @(negedge clk); #1;
        sample_outs("b2b_b2", 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0);
        @(negedge clk); #1;
        sample_outs("b2b_end", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
